spike_decoder: RTL
==================

Name: spike_decoder

Overview:
- Readout stage directly downstream of the spiking `network` core.
- Accumulates the per-neuron output spikes (`out_spikes`) over one classification window of N_CYCLES network timesteps.
- Selects the winning output neuron by maximum spike count and presents it to the host/controller through a valid/ready handshake.
- Per-neuron counts are also exposed for debug.

Parameters:
- N_OUT, 2: number of output neurons; width of `in_spikes`.
- N_CYCLES, 10: network timesteps per classification window (≥1).
- CYC_W, 5: width of the timestep counter; must satisfy 2^CYC_W > N_CYCLES.
- CNT_W, 5: width of each per-neuron spike counter (saturating).
- IDX_W, 1: width of `class_idx`; must satisfy 2^IDX_W ≥ N_OUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a new window; sampled only in IDLE.
- spikes_valid  in  1  one-cycle strobe per network timestep; `in_spikes` valid this cycle. Wired to the network's `sample` pulse.
- in_spikes  in  N_OUT  output spike vector from the network.
- busy  out  1  high in ACCUM and ARGMAX.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts the result when high together with `result_valid`.
- class_idx  out  IDX_W  index of the winning neuron.
- no_spike  out  1  every count was zero during the window; `class_idx` = 0 in that case.
- counts  out  N_OUT*CNT_W  flattened counters; neuron i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (`rst`=1 at a rising edge):
  - state = IDLE, all counters = 0, step_cnt = 0.
  - Outputs: `busy`=0, `result_valid`=0, `class_idx`=0, `no_spike`=0, `counts`=0.
  - Applies from any state, including mid-window; the partial window is discarded and no result is produced.
- FSM states: IDLE, ACCUM, ARGMAX, HOLD.
- IDLE:
  - `start`=1 → clear all counters and step_cnt; go to ACCUM next cycle.
  - `spikes_valid` in IDLE is ignored.
- ACCUM, on each cycle with `spikes_valid`=1:
  - counts[i] += in_spikes[i] for every i, saturating at 2^CNT_W-1 (no wrap).
  - step_cnt += 1.
  - If step_cnt == N_CYCLES-1 before the increment, this is the final timestep → go to ARGMAX.
  - Cycles with `spikes_valid`=0 leave all state unchanged; there is no timeout.
  - `start` is ignored while in ACCUM.
- ARGMAX (exactly one cycle):
  - Compare the final counts combinationally.
  - Register `class_idx` = lowest index holding the maximum count (ties resolve to the lower index).
  - Register `no_spike` = (all counts == 0).
  - Set `result_valid`=1; go to HOLD.
- HOLD:
  - `result_valid`=1; `class_idx`, `no_spike` and `counts` are stable.
  - `result_valid` & `result_ready` at a rising edge → `result_valid`=0 next cycle; go to IDLE. `counts` retains its value until the next `start`.
  - `start` in HOLD is ignored; results are never dropped.
  - `spikes_valid` in HOLD is ignored.
- Latency: the final `spikes_valid` is at cycle t; `counts` reflects it at t+1; `result_valid` rises at t+2.
- Back-to-back windows: `start` may be asserted in the first IDLE cycle after acceptance, so the minimum gap from acceptance to the new window is one cycle.
- `result_ready` held high permanently → `result_valid` is a single-cycle pulse.

Test Plan:
1. Reset, then `start`. Ten `spikes_valid` strobes with `in_spikes`=2'b01 on 7 of them and 2'b10 on 3, with `result_ready`=1.
   → counts = {3,7}, `class_idx`=0, `no_spike`=0, `result_valid` is a single pulse 2 cycles after the 10th strobe.
2. Tie: 5× 2'b11 followed by 5× 2'b00.
   → counts = {5,5}, `class_idx`=0 (lower-index tie-break).
3. All ten strobes carry 2'b00.
   → `no_spike`=1, `class_idx`=0. Separately, with CNT_W=3 and 10× 2'b10, count[1] saturates at 7 and `class_idx`=1.
4. Handshake: `result_ready` held low for 20 cycles after `result_valid` rises, with `start` and `spikes_valid` pulsed during the hold.
   → `result_valid`, `class_idx` and `counts` are unchanged throughout and `busy` stays 0. After `result_ready` is raised, the next `start` begins a clean window with counts = 0.
5. Mid-window reset: assert `rst` after 4 strobes.
   → all outputs return to reset values and state is IDLE. A fresh full window then produces correct counts with no carry-over.
6. Gapped strobes: ten strobes separated by random 0-7 idle cycles, each with 2'b10.
   → counts = {10,0}, `class_idx`=1, `busy` high from the cycle after `start` until the cycle `result_valid` rises.

Source files
------------

// File: rtl/spike_decoder_if.sv
// Host-side bundle for the spike decoder: window control, spike input and
// the valid/ready result channel with debug counters.
interface spike_decoder_if #(
    parameter int N_OUT = 2,
    parameter int CNT_W = 5,
    parameter int IDX_W = 1
);
    logic                   start;
    logic                   spikes_valid;
    logic [N_OUT-1:0]       in_spikes;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [IDX_W-1:0]       class_idx;
    logic                   no_spike;
    logic [N_OUT*CNT_W-1:0] counts;

    modport master (
        output start, spikes_valid, in_spikes, result_ready,
        input  busy, result_valid, class_idx, no_spike, counts
    );

    modport slave (
        input  start, spikes_valid, in_spikes, result_ready,
        output busy, result_valid, class_idx, no_spike, counts
    );
endinterface

// File: rtl/spike_decoder.sv
// Readout stage: counts output spikes over a window of N_CYCLES timesteps,
// then reports the neuron with the most spikes through a valid/ready handshake.
module spike_decoder #(
    parameter int N_OUT    = 2,
    parameter int N_CYCLES = 10,
    parameter int CYC_W    = 5,
    parameter int CNT_W    = 5,
    parameter int IDX_W    = 1
) (
    input logic             clk,
    input logic             rst,
    spike_decoder_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] ARGMAX = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [CYC_W-1:0] LAST_STEP = CYC_W'(N_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]             state;
    logic [CYC_W-1:0]       step_cnt;
    logic [CNT_W-1:0]       cnt [N_OUT];
    logic [IDX_W-1:0]       class_idx_q;
    logic                   no_spike_q;

    logic [IDX_W-1:0]       best_idx;
    logic [CNT_W-1:0]       best_val;
    logic                   any_spike;
    logic [N_OUT*CNT_W-1:0] counts_flat;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx  = '0;
        best_val  = cnt[0];
        any_spike = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (cnt[i] != '0) begin
                any_spike = 1'b1;
            end
            if (cnt[i] > best_val) begin
                best_val = cnt[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        counts_flat = '0;
        for (int i = 0; i < N_OUT; i++) begin
            counts_flat[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step_cnt    <= '0;
            class_idx_q <= '0;
            no_spike_q  <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        step_cnt <= '0;
                        for (int i = 0; i < N_OUT; i++) begin
                            cnt[i] <= '0;
                        end
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.spikes_valid) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (bus.in_spikes[i] && (cnt[i] != CNT_MAX)) begin
                                cnt[i] <= cnt[i] + CNT_W'(1);
                            end
                        end
                        step_cnt <= step_cnt + CYC_W'(1);
                        if (step_cnt == LAST_STEP) begin
                            state <= ARGMAX;
                        end
                    end
                end
                ARGMAX: begin
                    class_idx_q <= best_idx;
                    no_spike_q  <= ~any_spike;
                    state       <= HOLD;
                end
                HOLD: begin
                    // result_valid is implied by HOLD, so ready alone completes the handshake.
                    if (bus.result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state == ACCUM) || (state == ARGMAX);
    assign bus.result_valid = (state == HOLD);
    assign bus.class_idx    = class_idx_q;
    assign bus.no_spike     = no_spike_q;
    assign bus.counts       = counts_flat;
endmodule
